// File: rtl/multi_width_reg_bank_pkg.sv
// Shared types for the multi-width register bank: register selector
// encoding, clear-sweep state encoding and the channel-index width helper.
package multi_width_reg_bank_pkg;

   // Register selector shared by the write and read ports.
   typedef enum logic [1:0] {
      SEL_BIT    = 2'd0,
      SEL_NARROW = 2'd1,
      SEL_WIDE   = 2'd2,
      SEL_RSVD   = 2'd3
   } sel_e;

   // Clear-sweep controller states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } clr_state_e;

   // Channel-index width; a single channel still gets a 1-bit index.
   function automatic int calc_ch_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/reg_bank_channel.sv
// One channel of the bank: a 1-bit, a narrow and a wide register, each
// host-writable and free-running when enabled, plus two sticky wrap flags.
// Priority per register: clear > write > count.
module reg_bank_channel
   import multi_width_reg_bank_pkg::*;
#(
   parameter int W_NARROW = 8,
   parameter int W_WIDE   = 128
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_cnt_en,
   input  logic              i_clr,
   input  logic              i_wr_bit,
   input  logic              i_wr_narrow,
   input  logic              i_wr_wide,
   input  logic [W_WIDE-1:0] i_wr_data,
   output logic              o_bit,
   output logic [W_NARROW-1:0] o_narrow,
   output logic [W_WIDE-1:0] o_wide,
   output logic [1:0]        o_ovf
);

   logic              r_bit;
   logic [W_NARROW-1:0] r_narrow;
   logic [W_WIDE-1:0] r_wide;
   logic [1:0]        r_ovf;

   // Register update: reset/sweep clear, else write, else count; wraps set ovf.
   always_ff @(posedge i_clock) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (i_reset || i_clr) begin
         r_bit    <= 1'b0;
         r_narrow <= '0;
         r_wide   <= '0;
         r_ovf    <= 2'b00;
      end else begin
         if (i_wr_bit) begin
            r_bit <= i_wr_data[0];
         end else if (i_cnt_en) begin
            r_bit <= ~r_bit;
         end

         if (i_wr_narrow) begin
            r_narrow <= i_wr_data[W_NARROW-1:0];
         end else if (i_cnt_en) begin
            r_narrow <= r_narrow + W_NARROW'(1);
            if (&r_narrow) begin
               r_ovf[0] <= 1'b1;
            end
         end

         if (i_wr_wide) begin
            r_wide <= i_wr_data;
         end else if (i_cnt_en) begin
            r_wide <= r_wide + W_WIDE'(1);
            if (&r_wide) begin
               r_ovf[1] <= 1'b1;
            end
         end
      end
   end

   assign o_bit    = r_bit;
   assign o_narrow = r_narrow;
   assign o_wide   = r_wide;
   assign o_ovf    = r_ovf;

endmodule

// File: rtl/multi_width_reg_bank.sv
// Multi-channel register bank top: write decode, per-channel register
// instances, registered read mux with an RD_LAT-deep pipeline, and the
// sequential clear-sweep controller.
module multi_width_reg_bank
   import multi_width_reg_bank_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int W_NARROW = 8,
   parameter int W_WIDE   = 128,
   parameter int RD_LAT   = 2,
   localparam int CH_W    = calc_ch_w(NUM_CH)
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_wr_valid,
   output logic                o_wr_ready,
   input  logic [CH_W-1:0]     i_wr_ch,
   input  logic [1:0]          i_wr_sel,
   input  logic [W_WIDE-1:0]   i_wr_data,
   input  logic [NUM_CH-1:0]   i_cnt_en,
   input  logic                i_rd_req,
   input  logic [CH_W-1:0]     i_rd_ch,
   input  logic [1:0]          i_rd_sel,
   output logic                o_rd_valid,
   output logic [W_WIDE-1:0]   o_rd_data,
   output logic [2*NUM_CH-1:0] o_ovf,
   input  logic                i_clr_req,
   output logic                o_clr_busy,
   output logic                o_clr_done
);

   clr_state_e        r_clr_state;
   clr_state_e        w_clr_state_nxt;
   logic [CH_W-1:0]   r_clr_idx;
   logic [CH_W-1:0]   w_clr_idx_nxt;

   logic              w_wr_fire;
   sel_e              w_wr_sel;
   sel_e              w_rd_sel;
   logic [W_WIDE-1:0] w_rd_mux;

   logic              w_ch_bit    [NUM_CH];
   logic [W_NARROW-1:0] w_ch_narrow [NUM_CH];
   logic [W_WIDE-1:0] w_ch_wide   [NUM_CH];

   logic              r_pipe_vld  [RD_LAT];
   logic [W_WIDE-1:0] r_pipe_data [RD_LAT];

   assign w_wr_sel  = sel_e'(i_wr_sel);
   assign w_rd_sel  = sel_e'(i_rd_sel);
   assign w_wr_fire = i_wr_valid && o_wr_ready;

   // Clear-sweep state register and channel index.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_clr_state <= IDLE;
         r_clr_idx   <= '0;
      end else begin
         r_clr_state <= w_clr_state_nxt;
         r_clr_idx   <= w_clr_idx_nxt;
      end
   end

   // Clear-sweep next state and Moore outputs; writes are refused while sweeping.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case leaves a signal unassigned and no latch is inferred.
      w_clr_state_nxt = r_clr_state;
      w_clr_idx_nxt   = r_clr_idx;
      o_clr_busy      = 1'b0;
      o_clr_done      = 1'b0;
      o_wr_ready      = 1'b1;
      case (r_clr_state)
         IDLE: begin
            if (i_clr_req) begin
               w_clr_state_nxt = SWEEP;
               w_clr_idx_nxt   = '0;
            end
         end
         SWEEP: begin
            o_clr_busy = 1'b1;
            o_wr_ready = 1'b0;
            if (r_clr_idx == CH_W'(NUM_CH - 1)) begin
               w_clr_state_nxt = DONE;
            end else begin
               w_clr_idx_nxt = r_clr_idx + CH_W'(1);
            end
         end
         DONE: begin
            o_clr_done      = 1'b1;
            w_clr_state_nxt = IDLE;
         end
         default: begin
            w_clr_state_nxt = IDLE;
         end
      endcase
   end

   // One channel instance per index; out-of-range write channels never match.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic w_wr_hit;
      logic w_clr_hit;

      assign w_wr_hit  = w_wr_fire && (i_wr_ch == CH_W'(g));
      assign w_clr_hit = (r_clr_state == SWEEP) && (r_clr_idx == CH_W'(g));

      reg_bank_channel #(
         .W_NARROW (W_NARROW),
         .W_WIDE   (W_WIDE)
      ) u_ch (
         .i_clock     (i_clock),
         .i_reset     (i_reset),
         .i_cnt_en    (i_cnt_en[g]),
         .i_clr       (w_clr_hit),
         .i_wr_bit    (w_wr_hit && (w_wr_sel == SEL_BIT)),
         .i_wr_narrow (w_wr_hit && (w_wr_sel == SEL_NARROW)),
         .i_wr_wide   (w_wr_hit && (w_wr_sel == SEL_WIDE)),
         .i_wr_data   (i_wr_data),
         .o_bit       (w_ch_bit[g]),
         .o_narrow    (w_ch_narrow[g]),
         .o_wide      (w_ch_wide[g]),
         .o_ovf       (o_ovf[2*g +: 2])
      );
   end

   // Read mux over current register contents; unmatched channel or reserved sel reads 0.
   always_comb begin
      w_rd_mux = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (i_rd_ch == CH_W'(c)) begin
            case (w_rd_sel)
               SEL_BIT:    w_rd_mux = W_WIDE'(w_ch_bit[c]);
               SEL_NARROW: w_rd_mux = W_WIDE'(w_ch_narrow[c]);
               SEL_WIDE:   w_rd_mux = w_ch_wide[c];
               default:    w_rd_mux = '0;
            endcase
         end
      end
   end

   // Read pipeline: data stages only load on a valid beat, so the output holds.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         // NOTE: the pipeline is a small register array, not a RAM, so it is
         // reset in full; read data must come out of reset as zero.
         for (int i = 0; i < RD_LAT; i++) begin
            r_pipe_vld[i]  <= 1'b0;
            r_pipe_data[i] <= '0;
         end
      end else begin
         r_pipe_vld[0] <= i_rd_req;
         if (i_rd_req) begin
            r_pipe_data[0] <= w_rd_mux;
         end
         for (int i = 1; i < RD_LAT; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            if (r_pipe_vld[i-1]) begin
               r_pipe_data[i] <= r_pipe_data[i-1];
            end
         end
      end
   end

   assign o_rd_valid = r_pipe_vld[RD_LAT-1];
   assign o_rd_data  = r_pipe_data[RD_LAT-1];

endmodule

// File: tb/tb_multi_width_reg_bank.sv
// Bench for multi_width_reg_bank: directed scenarios followed by random
// traffic, every cycle compared against an arithmetic reference model.
module tb_multi_width_reg_bank;

   localparam int NUM_CH     = 2;
   localparam int W_NARROW   = 8;
   localparam int W_WIDE     = 128;
   localparam int RD_LAT     = 2;
   localparam int CH_W       = 1;
   localparam int NARROW_MAX = (1 << W_NARROW) - 1;

   logic                i_clock;
   logic                i_reset;
   logic                i_wr_valid;
   logic                o_wr_ready;
   logic [CH_W-1:0]     i_wr_ch;
   logic [1:0]          i_wr_sel;
   logic [W_WIDE-1:0]   i_wr_data;
   logic [NUM_CH-1:0]   i_cnt_en;
   logic                i_rd_req;
   logic [CH_W-1:0]     i_rd_ch;
   logic [1:0]          i_rd_sel;
   logic                o_rd_valid;
   logic [W_WIDE-1:0]   o_rd_data;
   logic [2*NUM_CH-1:0] o_ovf;
   logic                i_clr_req;
   logic                o_clr_busy;
   logic                o_clr_done;

   multi_width_reg_bank #(
      .NUM_CH   (NUM_CH),
      .W_NARROW (W_NARROW),
      .W_WIDE   (W_WIDE),
      .RD_LAT   (RD_LAT)
   ) dut (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_wr_valid (i_wr_valid),
      .o_wr_ready (o_wr_ready),
      .i_wr_ch    (i_wr_ch),
      .i_wr_sel   (i_wr_sel),
      .i_wr_data  (i_wr_data),
      .i_cnt_en   (i_cnt_en),
      .i_rd_req   (i_rd_req),
      .i_rd_ch    (i_rd_ch),
      .i_rd_sel   (i_rd_sel),
      .o_rd_valid (o_rd_valid),
      .o_rd_data  (o_rd_data),
      .o_ovf      (o_ovf),
      .i_clr_req  (i_clr_req),
      .o_clr_busy (o_clr_busy),
      .o_clr_done (o_clr_done)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: register values as plain numbers, sweep as a position.
   // m_pos: -1 idle, 0..NUM_CH-1 clearing that channel, NUM_CH done pulse.
   bit                m_bit    [NUM_CH];
   int                m_narrow [NUM_CH];
   logic [W_WIDE-1:0] m_wide   [NUM_CH];
   logic [2*NUM_CH-1:0] m_ovf;
   int                m_pos;
   logic [W_WIDE-1:0] m_rd_last;

   typedef struct {
      int                due;
      logic [W_WIDE-1:0] data;
   } rd_t;
   rd_t rq[$];

   task automatic check(input string tag, input logic [W_WIDE-1:0] obs,
                        input logic [W_WIDE-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W_WIDE-1:0] model_read(input int ch, input int sel);
      if (ch >= NUM_CH) return '0;
      case (sel)
         0:       return W_WIDE'(m_bit[ch]);
         1:       return W_WIDE'(m_narrow[ch]);
         2:       return m_wide[ch];
         default: return '0;
      endcase
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_bit[c]    = 1'b0;
         m_narrow[c] = 0;
         m_wide[c]   = '0;
      end
      m_ovf     = '0;
      m_pos     = -1;
      m_rd_last = '0;
      rq.delete();
   endtask

   // Advance one clock: update the model from the inputs about to be
   // sampled, take the edge, then compare every output.
   task automatic tick();
      logic rst;
      logic busy;
      logic hit;
      logic exp_valid;
      rd_t  e;
      rst  = i_reset;
      busy = (m_pos >= 0) && (m_pos < NUM_CH);
      if (rst) begin
         model_reset();
      end else begin
         if (i_rd_req) begin
            e.due  = cyc + RD_LAT;
            e.data = model_read(int'(i_rd_ch), int'(i_rd_sel));
            rq.push_back(e);
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (busy && m_pos == c) begin
               m_bit[c]      = 1'b0;
               m_narrow[c]   = 0;
               m_wide[c]     = '0;
               m_ovf[2*c]    = 1'b0;
               m_ovf[2*c+1]  = 1'b0;
            end else begin
               hit = i_wr_valid && !busy && (int'(i_wr_ch) == c);
               if (hit && i_wr_sel == 2'd0) m_bit[c] = i_wr_data[0];
               else if (i_cnt_en[c])        m_bit[c] = !m_bit[c];
               if (hit && i_wr_sel == 2'd1) begin
                  m_narrow[c] = int'(i_wr_data[W_NARROW-1:0]);
               end else if (i_cnt_en[c]) begin
                  if (m_narrow[c] == NARROW_MAX) begin
                     m_narrow[c] = 0;
                     m_ovf[2*c]  = 1'b1;
                  end else begin
                     m_narrow[c] = m_narrow[c] + 1;
                  end
               end
               if (hit && i_wr_sel == 2'd2) begin
                  m_wide[c] = i_wr_data;
               end else if (i_cnt_en[c]) begin
                  if (m_wide[c] == {W_WIDE{1'b1}}) m_ovf[2*c+1] = 1'b1;
                  m_wide[c] = m_wide[c] + 1'b1;
               end
            end
         end
         if (m_pos < 0) begin
            if (i_clr_req) m_pos = 0;
         end else if (m_pos < NUM_CH) begin
            m_pos = m_pos + 1;
         end else begin
            m_pos = -1;
         end
      end
      @(posedge i_clock);
      cyc++;
      #1;
      exp_valid = 1'b0;
      if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
         exp_valid = 1'b1;
         m_rd_last = rq[0].data;
         void'(rq.pop_front());
      end
      check("rd_valid", o_rd_valid, exp_valid);
      check("rd_data", o_rd_data, m_rd_last);
      check("ovf", o_ovf, m_ovf);
      check("clr_busy", o_clr_busy, (m_pos >= 0) && (m_pos < NUM_CH));
      check("clr_done", o_clr_done, m_pos == NUM_CH);
      check("wr_ready", o_wr_ready, !((m_pos >= 0) && (m_pos < NUM_CH)));
   endtask

   task automatic do_write(input int ch, input int sel, input logic [W_WIDE-1:0] d);
      i_wr_valid = 1'b1;
      i_wr_ch    = CH_W'(ch);
      i_wr_sel   = 2'(sel);
      i_wr_data  = d;
      tick();
      i_wr_valid = 1'b0;
   endtask

   // Single read: valid must stay low until exactly RD_LAT edges after the request.
   task automatic do_read(input int ch, input int sel, input logic [W_WIDE-1:0] exp,
                          input string tag);
      i_rd_req = 1'b1;
      i_rd_ch  = CH_W'(ch);
      i_rd_sel = 2'(sel);
      tick();
      i_rd_req = 1'b0;
      for (int k = 1; k < RD_LAT; k++) begin
         check({tag, "_early"}, o_rd_valid, 1'b0);
         tick();
      end
      check({tag, "_valid"}, o_rd_valid, 1'b1);
      check(tag, o_rd_data, exp);
   endtask

   logic [W_WIDE-1:0] pattern;
   logic [63:0]       pattern_hi;
   logic [W_WIDE-1:0] rnd;

   initial begin
      i_reset = 1'b1; i_wr_valid = 1'b0; i_wr_ch = '0; i_wr_sel = '0;
      i_wr_data = '0; i_cnt_en = '0; i_rd_req = 1'b0; i_rd_ch = '0;
      i_rd_sel = '0; i_clr_req = 1'b0;
      model_reset();
      tick();
      tick();
      i_reset = 1'b0;
      check("reset_ovf", o_ovf, 4'b0000);
      check("reset_wr_ready", o_wr_ready, 1'b1);
      check("reset_rd_data", o_rd_data, '0);

      // Count ch0 five times, ch1 idle.
      i_cnt_en = 2'b01;
      repeat (5) tick();
      i_cnt_en = 2'b00;
      do_read(0, 1, 5, "ch0_narrow_5");
      do_read(0, 0, 1, "ch0_bit_1");
      do_read(1, 1, 0, "ch1_narrow_0");
      do_read(0, 2, 5, "ch0_wide_5");

      // Narrow wrap on ch1 sets its narrow ovf only.
      do_write(1, 1, 'hFE);
      i_cnt_en = 2'b10;
      repeat (2) tick();
      i_cnt_en = 2'b00;
      check("ovf2_set", o_ovf[2], 1'b1);
      check("ovf3_clear", o_ovf[3], 1'b0);
      do_read(1, 1, 0, "ch1_narrow_wrap");
      do_read(1, 2, 2, "ch1_wide_2");
      check("ovf2_sticky", o_ovf[2], 1'b1);

      // Wide wrap on ch0, then a full-width write/readback.
      do_write(0, 2, {W_WIDE{1'b1}});
      i_cnt_en = 2'b01;
      tick();
      i_cnt_en = 2'b00;
      check("ovf1_set", o_ovf[1], 1'b1);
      check("ovf0_clear", o_ovf[0], 1'b0);
      do_read(0, 2, 0, "ch0_wide_wrap");
      pattern = 128'h0123_4567_89AB_CDEF_1357_9BDF_0246_CDEF;
      do_write(0, 2, pattern);
      do_read(0, 2, pattern, "ch0_wide_pattern");
      pattern_hi = pattern[127:64];
      check("ch0_wide_hi64", o_rd_data[127:64], pattern_hi);

      // Write beats count on the same register; others still count.
      i_cnt_en = 2'b01;
      do_write(0, 1, 'h10);
      i_cnt_en = 2'b00;
      do_read(0, 1, 'h10, "ch0_narrow_write_wins");
      do_read(0, 0, 1, "ch0_bit_toggles");
      do_read(0, 2, pattern + 1'b1, "ch0_wide_counts");

      // Clear sweep: busy two cycles, write refused while busy, done on cycle 3.
      i_clr_req = 1'b1;
      tick();
      i_clr_req = 1'b0;
      check("sweep_busy1", o_clr_busy, 1'b1);
      check("sweep_ready1", o_wr_ready, 1'b0);
      i_clr_req  = 1'b1;
      i_wr_valid = 1'b1; i_wr_ch = 1'b0; i_wr_sel = 2'd1; i_wr_data = 'h55;
      tick();
      i_clr_req  = 1'b0;
      check("sweep_busy2", o_clr_busy, 1'b1);
      check("sweep_ready2", o_wr_ready, 1'b0);
      tick();
      i_wr_valid = 1'b0;
      check("sweep_done", o_clr_done, 1'b1);
      check("sweep_busy_off", o_clr_busy, 1'b0);
      tick();
      check("sweep_done_pulse", o_clr_done, 1'b0);
      check("sweep_ovf_zero", o_ovf, 4'b0000);
      do_read(0, 1, 0, "swept_ch0_narrow");
      do_read(0, 2, 0, "swept_ch0_wide");
      do_read(1, 1, 0, "swept_ch1_narrow");

      // Reset during a sweep with a read in flight aborts both.
      i_cnt_en = 2'b11;
      repeat (3) tick();
      i_cnt_en = 2'b00;
      i_clr_req = 1'b1; i_rd_req = 1'b1; i_rd_ch = 1'b0; i_rd_sel = 2'd1;
      tick();
      i_clr_req = 1'b0; i_rd_req = 1'b0;
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      check("abort_busy", o_clr_busy, 1'b0);
      check("abort_rd_valid", o_rd_valid, 1'b0);
      check("abort_rd_data", o_rd_data, '0);
      tick();
      check("abort_no_done", o_clr_done, 1'b0);

      // Back-to-back reads return in order on consecutive cycles, then hold.
      do_write(0, 1, 'h21);
      do_write(1, 1, 'h42);
      i_rd_req = 1'b1; i_rd_ch = 1'b0; i_rd_sel = 2'd1;
      tick();
      i_rd_ch = 1'b1;
      tick();
      i_rd_req = 1'b0;
      check("b2b_first_valid", o_rd_valid, 1'b1);
      check("b2b_first", o_rd_data, 'h21);
      tick();
      check("b2b_second_valid", o_rd_valid, 1'b1);
      check("b2b_second", o_rd_data, 'h42);
      tick();
      check("b2b_hold_valid", o_rd_valid, 1'b0);
      check("b2b_hold", o_rd_data, 'h42);

      // Random traffic against the model.
      repeat (600) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 3) == 0) rnd[W_NARROW-1:0] = 8'(NARROW_MAX - $urandom_range(0, 2));
         if ($urandom_range(0, 7) == 0) rnd = {W_WIDE{1'b1}} - W_WIDE'($urandom_range(0, 2));
         i_wr_valid = ($urandom_range(0, 2) == 0);
         i_wr_ch    = CH_W'($urandom_range(0, 1));
         i_wr_sel   = 2'($urandom_range(0, 3));
         i_wr_data  = rnd;
         i_cnt_en   = NUM_CH'($urandom_range(0, 3));
         i_rd_req   = ($urandom_range(0, 1) == 0);
         i_rd_ch    = CH_W'($urandom_range(0, 1));
         i_rd_sel   = 2'($urandom_range(0, 3));
         i_clr_req  = ($urandom_range(0, 39) == 0);
         i_reset    = ($urandom_range(0, 199) == 0);
         tick();
      end
      i_reset = 1'b0; i_wr_valid = 1'b0; i_cnt_en = '0; i_rd_req = 1'b0; i_clr_req = 1'b0;
      repeat (RD_LAT + 1) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
